// File: rtl/seg_scan_2dig.sv
// Two-digit seven-segment scan multiplexer with dead-time blanking and frame-boundary commit.
// Optional leading-zero blanking of the tens digit: define SEG_SCAN_LZB_EN.
module seg_scan_2dig #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [6:0] d1_in,
    input  logic [6:0] d0_in,
    output logic [6:0] seg_out,
    output logic [1:0] an,
    output logic       upd_ack,
    output logic       frame_tick
);

    // state  | meaning
    // D0_ON  | units digit lit, an=01
    // BLANK0 | dead time after units, an=00
    // D1_ON  | tens digit lit, an=10
    // BLANK1 | dead time after tens, an=00; frame ends here
    typedef enum logic [1:0] {D0_ON, BLANK0, D1_ON, BLANK1} state_t;

    localparam int DWELL_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW        = $clog2(DWELL_MAX + 1);
    localparam int BLANK_M1  = (BLANK > 0) ? BLANK - 1 : 0;
    localparam logic [CW-1:0] ON_LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_M1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          boundary;
    logic [6:0]    sh_d1, sh_d0;
    logic          pending;
    logic [6:0]    act_d1, act_d0, act_d1_nxt, act_d0_nxt;
    logic [6:0]    seg_nxt;
    logic [1:0]    an_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CW'(1);
        boundary   = 1'b0;
        act_d1_nxt = act_d1;
        act_d0_nxt = act_d0;
        seg_nxt    = 7'd0;
        an_nxt     = 2'b00;

        case (state)
            D0_ON:  if (cnt == ON_LAST) state_nxt = (BLANK > 0) ? BLANK0 : D1_ON;
            BLANK0: if (cnt == BLANK_LAST) state_nxt = D1_ON;
            D1_ON: begin
                if (cnt == ON_LAST) begin
                    if (BLANK > 0) begin
                        state_nxt = BLANK1;
                    end else begin
                        state_nxt = D0_ON;
                        boundary  = 1'b1;
                    end
                end
            end
            BLANK1: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = D0_ON;
                    boundary  = 1'b1;
                end
            end
            default: state_nxt = D0_ON;
        endcase

        if (state_nxt != state) cnt_nxt = '0;

        // A load in the boundary cycle itself bypasses the shadow.
        if (boundary) begin
            if (load) begin
                act_d1_nxt = d1_in;
                act_d0_nxt = d0_in;
            end else if (pending) begin
                act_d1_nxt = sh_d1;
                act_d0_nxt = sh_d0;
            end
        end

        // Outputs are registered, so decode from the next state and next active data.
        case (state_nxt)
            D0_ON: begin
                an_nxt  = 2'b01;
                seg_nxt = act_d0_nxt;
            end
            D1_ON: begin
`ifdef SEG_SCAN_LZB_EN
                if (act_d1_nxt != 7'b0111111) begin
                    an_nxt  = 2'b10;
                    seg_nxt = act_d1_nxt;
                end
`else
                an_nxt  = 2'b10;
                seg_nxt = act_d1_nxt;
`endif
            end
            default: begin
                an_nxt  = 2'b00;
                seg_nxt = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= D0_ON;
            cnt        <= '0;
            sh_d1      <= 7'd0;
            sh_d0      <= 7'd0;
            pending    <= 1'b0;
            act_d1     <= 7'd0;
            act_d0     <= 7'd0;
            seg_out    <= 7'd0;
            an         <= 2'b01;
            upd_ack    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            act_d1     <= act_d1_nxt;
            act_d0     <= act_d0_nxt;
            seg_out    <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= boundary;
            upd_ack    <= boundary && (load || pending);
            if (load) begin
                sh_d1 <= d1_in;
                sh_d0 <= d0_in;
            end
            if (boundary) pending <= 1'b0;
            else if (load) pending <= 1'b1;
        end
    end

endmodule
